// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754 multiplier with generic exponent/fraction widths, one
// shift-add step per cycle, valid/ready handshake and RNE/RTZ rounding.
module fp_mul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         round_mode,
  output logic [W-1:0] result,
  output logic [4:0]   flags,
  output logic         valid_out,
  input  logic         out_ready
);

  localparam int N  = MAN_W + 1;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

  state_t                state;
  logic [W-1:0]          a_r, b_r;
  logic                  rm_r, sign_r;
  logic signed [XW-1:0]  exp_sum;
  logic [N-1:0]          mcand;
  logic [2*N-1:0]        acc;
  logic [CW-1:0]         cnt;
  logic [MAN_W-1:0]      frac_r;
  logic                  guard, sticky;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea = a_r[W-2:MAN_W];
  assign eb = b_r[W-2:MAN_W];
  assign fa = a_r[MAN_W-1:0];
  assign fb = b_r[MAN_W-1:0];
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_zero = !(|ea);   // subnormals flush to zero
  assign b_zero = !(|eb);

  // Multiplier sits in the low half of acc and shifts out LSB first.
  logic [N:0] step_sum;
  assign step_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);

  logic                 rnd_inc, rnd_carry, ovf, unf;
  logic [MAN_W-1:0]     rnd_frac;
  logic signed [XW-1:0] e_fin;
  logic [W-1:0]         rnd_res;
  logic [4:0]           rnd_flags;

  always_comb begin
    rnd_inc = !rm_r && guard && (sticky || frac_r[0]);
    {rnd_carry, rnd_frac} = {1'b0, frac_r} + {{MAN_W{1'b0}}, rnd_inc};
    e_fin = exp_sum + $signed({{(XW-1){1'b0}}, rnd_carry});
    ovf = !e_fin[XW-1] && (e_fin >= EMAX);
    unf = e_fin[XW-1] || (e_fin == '0);
    rnd_res = {sign_r, e_fin[EXP_W-1:0], rnd_frac};
    rnd_flags = {guard | sticky, 4'b0000};
    if (ovf) begin
      rnd_res = rm_r ? {sign_r, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                     : {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 5'b10010;
    end else if (unf) begin
      rnd_res = {sign_r, {(W-1){1'b0}}};
      rnd_flags = 5'b10001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      valid_out <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      rm_r      <= 1'b0;
      sign_r    <= 1'b0;
      exp_sum   <= '0;
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      frac_r    <= '0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_r      <= op_a;
          b_r      <= op_b;
          rm_r     <= round_mode;
          in_ready <= 1'b0;
          state    <= S_UNPACK;
        end
        S_UNPACK: begin
          sign_r <= a_r[W-1] ^ b_r[W-1];
          if (a_nan || b_nan) begin
            result <= QNAN;
            flags  <= 5'b00000;
            valid_out <= 1'b1;
            state  <= S_DONE;
          end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            result <= QNAN;
            flags  <= 5'b01000;
            valid_out <= 1'b1;
            state  <= S_DONE;
          end else if (a_inf || b_inf || a_zero || b_zero) begin
            result <= (a_inf || b_inf)
                      ? {a_r[W-1] ^ b_r[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                      : {a_r[W-1] ^ b_r[W-1], {(W-1){1'b0}}};
            flags  <= 5'b00000;
            valid_out <= 1'b1;
            state  <= S_DONE;
          end else begin
            exp_sum <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
            mcand   <= {1'b1, fa};
            acc     <= {{N{1'b0}}, 1'b1, fb};
            cnt     <= CW'(N);
            state   <= S_MULT;
          end
        end
        S_MULT: begin
          acc <= {step_sum, acc[N-1:1]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_NORM;
        end
        S_NORM: begin
          if (acc[2*N-1]) begin
            frac_r  <= acc[2*N-2:N];
            guard   <= acc[N-1];
            sticky  <= |acc[N-2:0];
            exp_sum <= exp_sum + XW'(1);
          end else begin
            frac_r  <= acc[2*N-3:N-1];
            guard   <= acc[N-2];
            sticky  <= |acc[N-3:0];
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          result    <= rnd_res;
          flags     <= rnd_flags;
          valid_out <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          valid_out <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Directed bench for fp_mul_iter: single and half format instances, latency,
// special cases, rounding, overflow/underflow, back-pressure and mid-op reset.
module tb_fp_mul_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_start = 1'b0, s_in_ready, s_rm = 1'b0, s_valid, s_out_ready = 1'b0;
  logic [31:0] s_op_a = '0, s_op_b = '0, s_result;
  logic [4:0]  s_flags;

  logic        h_start = 1'b0, h_in_ready, h_rm = 1'b0, h_valid, h_out_ready = 1'b0;
  logic [15:0] h_op_a = '0, h_op_b = '0, h_result;
  logic [4:0]  h_flags;

  int checks = 0;
  int errors = 0;

  fp_mul_iter #(.EXP_W(8), .MAN_W(23)) u_sgl (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_ready(s_in_ready),
    .op_a(s_op_a), .op_b(s_op_b), .round_mode(s_rm), .result(s_result),
    .flags(s_flags), .valid_out(s_valid), .out_ready(s_out_ready)
  );

  fp_mul_iter #(.EXP_W(5), .MAN_W(10)) u_hlf (
    .clk(clk), .rst_n(rst_n), .start(h_start), .in_ready(h_in_ready),
    .op_a(h_op_a), .op_b(h_op_b), .round_mode(h_rm), .result(h_result),
    .flags(h_flags), .valid_out(h_valid), .out_ready(h_out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run_s(input logic [31:0] a, input logic [31:0] b, input logic rm,
                       input logic [31:0] er, input logic [4:0] ef, input int elat,
                       input string tag);
    int n;
    @(negedge clk);
    s_op_a = a; s_op_b = b; s_rm = rm; s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    n = 0;
    while (!s_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " result"}, s_result, er);
    check({tag, " flags"}, s_flags, ef);
    check({tag, " busy"}, s_in_ready, 0);
    @(negedge clk) s_out_ready = 1'b1;
    @(posedge clk); #1 s_out_ready = 1'b0;
    check({tag, " taken"}, s_valid, 0);
    check({tag, " ready"}, s_in_ready, 1);
  endtask

  task automatic run_h(input logic [15:0] a, input logic [15:0] b, input logic rm,
                       input logic [15:0] er, input logic [4:0] ef, input int elat,
                       input string tag);
    int n;
    @(negedge clk);
    h_op_a = a; h_op_b = b; h_rm = rm; h_start = 1'b1;
    @(posedge clk); #1 h_start = 1'b0;
    n = 0;
    while (!h_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, elat);
    check({tag, " result"}, h_result, er);
    check({tag, " flags"}, h_flags, ef);
    @(negedge clk) h_out_ready = 1'b1;
    @(posedge clk); #1 h_out_ready = 1'b0;
    check({tag, " taken"}, h_valid, 0);
    check({tag, " ready"}, h_in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check("rst valid", s_valid, 0);
    check("rst result", s_result, 0);
    check("rst flags", s_flags, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst in_ready", s_in_ready, 1);
    check("rst half in_ready", h_in_ready, 1);

    run_s(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 5'b00000, 27, "s 2x3");
    run_s(32'hC0A00000, 32'hC0400000, 1'b0, 32'h41700000, 5'b00000, 27, "s -5x-3");
    run_s(32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 5'b10010, 27, "s ovf rne");
    run_s(32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 5'b10010, 27, "s ovf rtz");
    run_s(32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 5'b10001, 27, "s unf");
    run_s(32'h80000001, 32'h3F800000, 1'b0, 32'h80000000, 5'b00000, 1,  "s subn");
    run_s(32'h3F800001, 32'h3F800001, 1'b0, 32'h3F800002, 5'b10000, 27, "s sq rne");
    run_s(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 5'b10000, 27, "s sq rtz");
    run_s(32'h3FC00000, 32'h3F800001, 1'b0, 32'h3FC00002, 5'b10000, 27, "s tie rne");
    run_s(32'h3FC00000, 32'h3F800001, 1'b1, 32'h3FC00001, 5'b10000, 27, "s tie rtz");

    run_h(16'h4000, 16'h4200, 1'b0, 16'h4600, 5'b00000, 14, "h 2x3");
    run_h(16'h7C00, 16'h0000, 1'b0, 16'h7E00, 5'b01000, 1,  "h inf*0");
    run_h(16'h7E00, 16'h4000, 1'b0, 16'h7E00, 5'b00000, 1,  "h nan");

    // back-pressure: result held, start pulses ignored, one completion only
    @(negedge clk);
    s_op_a = 32'h40000000; s_op_b = 32'h40400000; s_rm = 1'b0; s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    n = 0;
    while (!s_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp latency", n, 27);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_op_a = 32'h7FC00000; s_op_b = 32'h00000000; s_start = 1'b1;
      @(posedge clk); #1 s_start = 1'b0;
      check("bp valid", s_valid, 1);
      check("bp result", s_result, 32'h40C00000);
      check("bp flags", s_flags, 0);
      check("bp in_ready", s_in_ready, 0);
    end
    @(negedge clk) s_out_ready = 1'b1;
    @(posedge clk); #1 s_out_ready = 1'b0;
    check("bp taken", s_valid, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (s_valid) n++;
    end
    check("bp single completion", n, 0);

    // reset during MULT
    @(negedge clk);
    s_op_a = 32'h40000000; s_op_b = 32'h40400000; s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", s_valid, 0);
    check("midrst result", s_result, 0);
    check("midrst flags", s_flags, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", s_in_ready, 1);
    check("midrst valid after", s_valid, 0);
    run_s(32'hC0A00000, 32'hC0400000, 1'b0, 32'h41700000, 5'b00000, 27, "s after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_iter.md
Name: fp_mul_iter

Overview:
- Parametrised, iterative IEEE-754 multiplier for the mALUma FP datapath. Successor to the fixed half/single multiply path.
- Exponent and mantissa widths are generics, so one RTL covers half (5/10), single (8/23) or custom formats.
- Adds a full valid/ready handshake on both sides with output back-pressure, and a selectable rounding mode: round-to-nearest-even or round-toward-zero.
- Sits behind the ALU op decoder. Reports the same 5-bit flag vector as the ALU.

Parameters:
- EXP_W, 8: exponent field width. Must be ≥ 3.
- MAN_W, 23: stored mantissa (fraction) width. Must be ≥ 2.
- W, EXP_W+MAN_W+1: operand/result width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  operation request, qualified by in_ready
- in_ready  out  1  block can accept an operation
- op_a  in  W  operand A, IEEE layout {sign, exp, frac}
- op_b  in  W  operand B
- round_mode  in  1  0 = round-to-nearest-even, 1 = round-toward-zero; captured at accept
- result  out  W  product
- flags  out  5  [4] inexact, [3] invalid, [2] div-by-zero (always 0), [1] overflow, [0] underflow
- valid_out  out  1  result/flags valid
- out_ready  in  1  consumer takes result

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-operation):
  - state = IDLE; in_ready = 1 after release.
  - valid_out = 0, result = 0, flags = 0.
  - Accumulator and counter are cleared. Any in-flight operation is discarded.
- Accept edge E0 is a rising edge with start = 1 and in_ready = 1. On E0, op_a, op_b and round_mode are registered; in_ready drops to 0; state → UNPACK. start while in_ready = 0 is ignored.
- Bias = 2^(EXP_W-1) - 1. Internal exponent arithmetic is signed, EXP_W+2 bits.
- UNPACK (1 cycle): classify each operand as zero, subnormal, normal, Inf or NaN. Subnormal inputs are flushed to zero. Priority:
  - Either operand NaN → canonical qNaN {0, all-ones exp, 1, zeros}; flags 0.
  - Inf × zero → qNaN; invalid = 1.
  - Either operand Inf → ±Inf.
  - Either operand zero → ±0.
  - Special cases go directly to DONE. Sign is always a_sign XOR b_sign, except NaN (sign 0).
  - Otherwise: exp_sum = ea + eb - bias; load both significands with the hidden 1; counter = MAN_W+1; → MULT.
- MULT: one shift-add step per cycle, multiplier LSB first, for exactly MAN_W+1 cycles. Produces a 2·(MAN_W+1)-bit product, then → NORM.
- NORM (1 cycle): if product MSB = 1, shift right 1 and exp_sum += 1. Form guard and sticky bits from the discarded bits. → ROUND.
- ROUND (1 cycle):
  - RNE: increment when guard = 1 and (sticky = 1 or LSB = 1). Mantissa carry-out renormalises and increments the exponent.
  - RTZ: truncate.
  - inexact = guard OR sticky.
  - Overflow (exp ≥ 2^EXP_W - 1): RNE → ±Inf; RTZ → ±max finite. overflow = 1, inexact = 1.
  - Underflow (exp ≤ 0): flush to ±0. underflow = 1, inexact = 1.
  - → DONE.
- DONE: valid_out = 1; result and flags are held stable while out_ready = 0.
  - The edge with out_ready = 1 clears valid_out and returns to IDLE; in_ready = 1 on the following cycle. No same-cycle re-accept.
- Latency:
  - Special cases: valid_out high after E1.
  - Normal path: valid_out high after E(MAN_W+4). That is 27 edges for single, 14 for half.
- Throughput: one operation in flight. in_ready = 1 only in IDLE.

Test Plan:
- Single format, 0x40000000 × 0x40400000, RNE → after E27, result = 0x40C00000, flags = 0. Also 0xC0A00000 × 0xC0400000 → 0x41700000.
- Half format (EXP_W=5, MAN_W=10), 0x4000 × 0x4200 → 0x4600 after E14. 0x7C00 × 0x0000 → 0x7E00 with invalid, after E1. 0x7E00 × 0x4000 → 0x7E00, flags 0.
- Single, 0x7F000000 × 0x40000000:
  - RNE → 0x7F800000, flags = 10010.
  - RTZ → 0x7F7FFFFF, flags = 10010.
- Single, 0x00800000 × 0x3F000000 → 0x00000000, flags = 10001. Also 0x80000001 (subnormal) × 0x3F800000 → 0x80000000, flags 0.
- Single, 0x3F800001 × 0x3F800001 → 0x3F800002 with inexact, in both RNE and RTZ.
- Back-pressure and reset:
  - Hold out_ready = 0 for 5 cycles after valid_out. Result is stable, in_ready = 0, and start pulses are ignored. Release → one completion only.
  - Assert rst_n low during MULT → valid_out = 0 and result = 0 immediately. After release, a new operation completes correctly.
